if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  - Instruction-fetch stage of the 5-stage MIPS pipeline: holds the PC and registers the fetched word into IF/ID.
//  - Next-PC choice is PC+STEP or branch target, selected by one mux64_32 instance.
//  - Hazard unit stalls it with freeze; EX-stage branch resolution redirects and flushes it.
//  - Downstream is the ID stage (register file / control decode).
// PARAMETERS
//  - W         32      datapath / address width
//  - RESET_PC  32'h0   PC value loaded on reset
//  - PC_STEP   4       byte increment per sequential fetch
//  - CNT_W     16      width of the saturating stall counter
// PORTS
//  - clk            in   1    rising-edge clock
//  - rst            in   1    synchronous, active-high reset
//  - freeze         in   1    hazard stall: hold PC and IF/ID
//  - branch_taken   in   1    EX resolved a taken branch/jump this cycle
//  - branch_addr    in   W    redirect target byte address
//  - imem_data      in   W    instruction word at pc (combinational imem read)
//  - pc             out  W    current fetch address to imem
//  - if_id_pc4      out  W    registered pc+PC_STEP of fetched instr
//  - if_id_instr    out  W    registered instruction word
//  - if_id_valid    out  1    1 = IF/ID holds a real instruction, 0 = bubble
//  - stall_cnt      out  CNT_W  cycles with freeze=1 and no branch since reset, saturating
// BEHAVIOUR
//  - Reset (rst=1 at edge): pc<=RESET_PC, if_id_pc4<=0, if_id_instr<=0 (NOP), if_id_valid<=0, stall_cnt<=0.
//  - Priority each edge: rst > branch_taken > freeze > normal advance.
//  - Normal (rst=0, branch_taken=0, freeze=0):
//    - pc<=pc+PC_STEP.
//    - if_id_instr<=imem_data, if_id_pc4<=pc+PC_STEP, if_id_valid<=1.
//  - Freeze only: pc and all if_id_* hold; stall_cnt<=stall_cnt+1, saturating at all-ones.
//  - Branch (with or without freeze):
//    - pc<={branch_addr[W-1:2],2'b00}; low bits are forced to zero, no fault raised.
//    - IF/ID flushed: if_id_valid<=0, if_id_instr<=0, if_id_pc4 holds.
//    - stall_cnt not incremented.
//  - Latency: instruction addressed by pc appears on if_id_instr one edge later (unless frozen/flushed).
//  - Wrap: pc+PC_STEP is modulo 2^W; 32'hFFFFFFFC advances to 32'h0 silently.
//  - Reset mid-stall or mid-branch: reset wins; first fetch after rst release is at RESET_PC.
//  - Branch target equal to current pc is legal: pc unchanged, IF/ID still flushed.
//  - pc and if_id_* change only at clk edges; no combinational path from freeze/branch_* to outputs.
// STRUCTURE
//  - Shared package mips_pkg:
//    - W (32), PC_STEP (4), RESET_PC, NOP encoding 32'h0.
//  - Sub-module: one mux64_32 instance, i.e. next_pc = s ? b : a.
//    - a=pc+PC_STEP, b=aligned branch_addr, s=branch_taken.
//  - Rest is flat: pc register, IF/ID register, stall counter.
// TESTING
//  1. Reset, then 4 free-running cycles with imem_data=32'h20080005
//     -> pc 0,4,8,12,16; if_id_pc4=16; if_id_valid=1 from the 1st edge after rst drop.
//  2. freeze=1 for 3 cycles at pc=8
//     -> pc stays 8, if_id_instr/pc4 unchanged, stall_cnt=3; resume gives pc=12.
//  3. branch_taken=1, branch_addr=32'h00000043 at pc=20
//     -> next pc=32'h40, if_id_valid=0, if_id_instr=0; following cycle valid=1 with pc4=32'h44.
//  4. branch_taken=1 and freeze=1 together, target 32'h100
//     -> pc=32'h100, IF/ID flushed, stall_cnt unchanged.
//  5. RESET_PC=32'hFFFFFFF8, 3 free cycles
//     -> pc FFFFFFF8, FFFFFFFC, 0, 4; no X on any output.
//  6. rst asserted while freeze=1 and branch_taken=1 -> all outputs at reset values next edge.
//     Force stall_cnt to 16'hFFFE, freeze 3 cycles -> saturates at 16'hFFFF.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the MIPS pipeline stages.
package mips_pkg;

    localparam int          W        = 32;
    localparam int          PC_STEP  = 4;
    localparam int          CNT_W    = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0000;

    // Instruction fetches are word aligned: the two byte-offset bits are dropped.
    function automatic logic [W-1:0] word_align(input logic [W-1:0] addr);
        return {addr[W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/mux64_32.sv
// Two-input word multiplexer: y = s ? b : a.
module mux64_32 #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         s,
    output logic [W-1:0] y
);

    // Pure select, no state.
    always_comb begin
        y = s ? b : a;
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a
// saturating counter of hazard-stall cycles.
//
// Per-edge priority: rst > branch_taken > freeze > sequential advance.
// A taken branch redirects the PC and flushes IF/ID even when the hazard
// unit is also asking for a stall, because the stalled instruction is on
// the wrong path anyway.
module if_stage
    import mips_pkg::*;
#(
    parameter int          W        = mips_pkg::W,
    parameter logic [31:0] RESET_PC = mips_pkg::RESET_PC,
    parameter int          PC_STEP  = mips_pkg::PC_STEP,
    parameter int          CNT_W    = mips_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic             branch_taken,
    input  logic [W-1:0]     branch_addr,
    input  logic [W-1:0]     imem_data,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     if_id_pc4,
    output logic [W-1:0]     if_id_instr,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [W-1:0] pc_seq;
    logic [W-1:0] branch_tgt;
    logic [W-1:0] next_pc;

    // Sequential address wraps modulo 2^W; the redirect target is forced word aligned.
    always_comb begin
        pc_seq     = pc + W'(PC_STEP);
        branch_tgt = word_align(branch_addr);
    end

    mux64_32 #(.W(W)) u_next_pc_mux (
        .a (pc_seq),
        .b (branch_tgt),
        .s (branch_taken),
        .y (next_pc)
    );

    // PC, IF/ID and stall counter update with reset > branch > freeze > advance priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC[W-1:0];
            if_id_pc4   <= '0;
            if_id_instr <= NOP[W-1:0];
            if_id_valid <= 1'b0;
            stall_cnt   <= '0;
        end else if (branch_taken) begin
            // Redirect and flush; if_id_pc4 keeps its last value.
            pc          <= next_pc;
            if_id_instr <= NOP[W-1:0];
            if_id_valid <= 1'b0;
        end else if (freeze) begin
            // Hold PC and IF/ID; count the stall, sticking at all-ones.
            if (stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end else begin
            pc          <= next_pc;
            if_id_instr <= imem_data;
            if_id_pc4   <= pc_seq;
            if_id_valid <= 1'b1;
        end
    end

endmodule
